// File: rtl/sync_nff_filt_pkg.sv
// Shared constants and helpers for the multi-stage synchronizer family.
package sync_nff_filt_pkg;

    // Legal synchronizer depth range.
    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned SYNC_STAGES_MAX = 4;

    // Default filter length: bypassed, suitable for gray-coded pointers.
    localparam int unsigned SYNC_FILTER_DEF = 0;

    // Widest vector popcount accepts; narrower callers zero-extend.
    localparam int unsigned POPCOUNT_W = 64;

    // Number of set bits in v.
    function automatic int unsigned popcount(input logic [POPCOUNT_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned b = 0; b < POPCOUNT_W; b++) begin
            n = n + 32'(v[b]);
        end
        return n;
    endfunction

endpackage : sync_nff_filt_pkg

// File: rtl/sync_nff_filt_filter_ch.sv
// Single-channel stability filter plus rise/fall edge detection.
// FILTER_CYCLES = 0 passes the synchronized bit straight to q.
module sync_filter_ch
    import sync_nff_filt_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = SYNC_FILTER_DEF,
    parameter logic        RESET_BIT     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sync,
    output logic q,
    output logic rise,
    output logic fall
);

    logic q_prev;

    if (FILTER_CYCLES == 0) begin : g_bypass
        assign q = sync;
    end else begin : g_filt
        localparam int unsigned CW = $clog2(FILTER_CYCLES + 1);

        logic          filt;
        logic [CW-1:0] cnt;

        // Accept a new value only after it persists FILTER_CYCLES samples; any match restarts the count.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                filt <= RESET_BIT;
                cnt  <= '0;
            end else if (sync == filt) begin
                cnt  <= '0;
            end else if (cnt == CW'(FILTER_CYCLES - 1)) begin
                filt <= sync;
                cnt  <= '0;
            end else begin
                cnt  <= cnt + CW'(1);
            end
        end

        assign q = filt;
    end

    // Previous q for edge decoding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_prev <= RESET_BIT;
        end else begin
            q_prev <= q;
        end
    end

    // Both terms come from registers, so rise and fall are mutually exclusive one-cycle pulses.
    assign rise = q & ~q_prev;
    assign fall = ~q & q_prev;

endmodule : sync_filter_ch

// File: rtl/sync_nff_filt.sv
// Parametrised multi-stage, multi-channel synchronizer with optional
// per-channel glitch filter and registered rise/fall pulses.
// Optional feature macro: SYNC_GRAY_CHECK_EN enables the sticky
// multi-bit-change detector (gray_err); otherwise gray_err is tied 0.
module sync_nff_filt
    import sync_nff_filt_pkg::*;
#(
    parameter int unsigned      WIDTH         = 1,
    parameter int unsigned      STAGES        = 2,
    parameter int unsigned      FILTER_CYCLES = SYNC_FILTER_DEF,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    input  logic             err_clr,
    output logic             gray_err
);

    if ((STAGES < SYNC_STAGES_MIN) || (STAGES > SYNC_STAGES_MAX)) begin : g_bad_stages
        $error("sync_nff_filt: STAGES=%0d outside legal range %0d..%0d",
               STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
    end

    if (WIDTH < 1) begin : g_bad_width
        $error("sync_nff_filt: WIDTH must be at least 1");
    end

    logic [WIDTH-1:0] stage [STAGES];
    logic [WIDTH-1:0] sync;

    // Synchronizer chain: stage[0] captures the asynchronous input, the rest resolve metastability.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < STAGES; k++) begin
                stage[k] <= RESET_VAL;
            end
        end else begin
            stage[0] <= d;
            for (int k = 1; k < STAGES; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    assign sync = stage[STAGES-1];

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        sync_filter_ch #(
            .FILTER_CYCLES (FILTER_CYCLES),
            .RESET_BIT     (RESET_VAL[i])
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .sync (sync[i]),
            .q    (q[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

`ifdef SYNC_GRAY_CHECK_EN
    if (WIDTH > 1) begin : g_gray
        logic [WIDTH-1:0] sync_prev;
        logic             multi_chg;
        logic             err_r;

        if (WIDTH > POPCOUNT_W) begin : g_bad_gray_width
            $error("sync_nff_filt: gray check limited to %0d channels", POPCOUNT_W);
        end

        // Flag any cycle where more than one synchronized bit changed; sticky until cleared, set beats clear.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync_prev <= RESET_VAL;
                multi_chg <= 1'b0;
                err_r     <= 1'b0;
            end else begin
                sync_prev <= sync;
                multi_chg <= popcount(POPCOUNT_W'(sync ^ sync_prev)) > 32'd1;
                err_r     <= multi_chg | (err_r & ~err_clr);
            end
        end

        assign gray_err = err_r;
    end else begin : g_gray_single
        // A single channel can never change by more than one bit.
        logic unused_err_clr;
        assign unused_err_clr = err_clr;
        assign gray_err       = 1'b0;
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign gray_err       = 1'b0;
`endif

endmodule : sync_nff_filt
